// File: rtl/imem_loader_pkg.sv
// -----------------------------------------------------------------------------
// imem_loader_pkg
// Shared definitions for the instruction-memory loader of the image
// downsampling processor:
//   - loader/run mode state encoding
//   - default geometry of the instruction memory
//   - NOP/HALT opcode returned on an out-of-range fetch
// -----------------------------------------------------------------------------
package imem_loader_pkg;

  // Default geometry: 512 x 8-bit instruction words.
  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned ADDR_W_DEF = 9;
  localparam int unsigned DEPTH_DEF  = 512;

  // Opcode the control unit treats as NOP/HALT. It is returned for fetches
  // beyond the loaded program so a runaway PC cannot execute stale words.
  localparam logic [7:0] OP_NOP = 8'h00;

  // Loader / run mode.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // no program loaded since reset
    ST_LOAD = 2'd1,  // accepting program words from the loader front end
    ST_RUN  = 2'd2   // program complete, serving fetches
  } state_e;

endpackage : imem_loader_pkg

// File: rtl/imem_ram.sv
// -----------------------------------------------------------------------------
// imem_ram
// Single-port synchronous instruction RAM (DEPTH x DATA_W). One shared
// address serves either a write or a read in a given cycle; the read data is
// registered so the array maps onto block RAM.
//
// Ports:
//   clk    in   clock
//   rstN   in   async active-low reset (read register only)
//   we     in   write enable: mem[addr] <= wdata
//   re     in   read enable:  rdata <= mem[addr] on the next edge
//   addr   in   ADDR_W word address
//   wdata  in   DATA_W write data
//   rdata  out  DATA_W registered read data, holds when re is low
// -----------------------------------------------------------------------------
module imem_ram #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DEPTH  = 512
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // NOTE: the storage array has no reset; a reset on it would prevent block
  // RAM inference and every word reachable by a fetch is written by a load
  // first. Only the output register is reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem[addr];
    end
  end

  assign rdata = rdata_q;

endmodule : imem_ram

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// Instruction memory with a run-time program-load port. A host/UART front end
// streams the program in (LOAD), after which the control unit fetches from it
// (RUN) with a one-cycle latency, a valid pulse and program-length bounds
// checking.
//
// Ports:
//   clk         in   clock, all state changes on the rising edge
//   rstN        in   async active-low reset
//   loadStart   in   begin / restart a program load (wins over FETCH)
//   loadValid   in   loadData valid this cycle
//   loadData    in   program word
//   loadLast    in   loadData is the final word of the program
//   loadReady   out  high while in LOAD
//   loadDone    out  one-cycle pulse after the final word is stored
//   FETCH       in   fetch request from the control unit
//   iAddr       in   fetch address
//   instr       out  fetched instruction (FILL_WORD when out of range)
//   instrValid  out  one-cycle pulse, instr updated this cycle
//   addrErr     out  one-cycle pulse, fetch address >= progLen
//   progLen     out  word count of the last completed load
//   running     out  high while in RUN
// -----------------------------------------------------------------------------
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned       DATA_W    = DATA_W_DEF,
  parameter int unsigned       ADDR_W    = ADDR_W_DEF,
  parameter int unsigned       DEPTH     = DEPTH_DEF,
  parameter logic [DATA_W-1:0] FILL_WORD = DATA_W'(OP_NOP)
) (
  input  logic              clk,
  input  logic              rstN,
  // loader front end
  input  logic              loadStart,
  input  logic              loadValid,
  input  logic [DATA_W-1:0] loadData,
  input  logic              loadLast,
  output logic              loadReady,
  output logic              loadDone,
  // control unit fetch port
  input  logic              FETCH,
  input  logic [ADDR_W-1:0] iAddr,
  output logic [DATA_W-1:0] instr,
  output logic              instrValid,
  output logic              addrErr,
  // status
  output logic [ADDR_W:0]   progLen,
  output logic              running
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e            state_q;
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W:0]   prog_len_q;
  logic [ADDR_W:0]   prog_len_d;
  logic              load_ready_q;
  logic              load_done_q;
  logic              running_q;
  logic              instr_valid_q;
  logic              addr_err_q;
  logic              fill_sel_q;

  logic              in_range;
  logic              load_word;
  logic              last_word;
  logic              fetch_ok;
  logic              ram_we;
  logic              ram_re;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_rdata;

  // A fetch is in range only below the length of the last completed load.
  // progLen never exceeds DEPTH, so in-range addresses are always inside
  // the array.
  assign in_range = ({1'b0, iAddr} < prog_len_q);

  // loadStart in LOAD restarts the load and suppresses that cycle's write.
  assign load_word = (state_q == ST_LOAD) && loadValid && !loadStart;

  // The load ends on an explicit last word or when the array is full, so a
  // write past DEPTH-1 cannot happen.
  assign last_word = loadLast || (wr_ptr_q == LAST_ADDR);

  // loadStart in RUN drops a coincident fetch.
  assign fetch_ok = (state_q == ST_RUN) && FETCH && !loadStart;

  assign prog_len_d = {1'b0, wr_ptr_q} + (ADDR_W + 1)'(1);

  // Writes happen only in LOAD and reads only in RUN, so one shared address
  // port is enough.
  assign ram_we   = load_word;
  assign ram_re   = fetch_ok && in_range;
  assign ram_addr = (state_q == ST_LOAD) ? wr_ptr_q : iAddr;

  imem_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .rstN  (rstN),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (loadData),
    .rdata (ram_rdata)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side below sees the pre-edge value regardless of order; the
  // pulse defaults at the top are then safely overridden by the case.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q       <= ST_IDLE;
      wr_ptr_q      <= '0;
      prog_len_q    <= '0;
      load_ready_q  <= 1'b0;
      load_done_q   <= 1'b0;
      running_q     <= 1'b0;
      instr_valid_q <= 1'b0;
      addr_err_q    <= 1'b0;
      fill_sel_q    <= 1'b0;
    end else begin
      // Single-cycle pulses.
      load_done_q   <= 1'b0;
      instr_valid_q <= 1'b0;
      addr_err_q    <= 1'b0;

      unique case (state_q)
        ST_IDLE: begin
          if (loadStart) begin
            state_q      <= ST_LOAD;
            wr_ptr_q     <= '0;
            load_ready_q <= 1'b1;
          end
        end

        ST_LOAD: begin
          if (loadStart) begin
            wr_ptr_q <= '0;
          end else if (loadValid) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
            if (last_word) begin
              prog_len_q   <= prog_len_d;
              load_done_q  <= 1'b1;
              state_q      <= ST_RUN;
              load_ready_q <= 1'b0;
              running_q    <= 1'b1;
            end
          end
        end

        ST_RUN: begin
          if (loadStart) begin
            // progLen keeps the old program length until the new load ends.
            state_q      <= ST_LOAD;
            wr_ptr_q     <= '0;
            load_ready_q <= 1'b1;
            running_q    <= 1'b0;
          end else if (FETCH) begin
            instr_valid_q <= 1'b1;
            addr_err_q    <= !in_range;
            fill_sel_q    <= !in_range;
          end
        end

        default: begin
          state_q      <= ST_IDLE;
          load_ready_q <= 1'b0;
          running_q    <= 1'b0;
        end
      endcase
    end
  end

  // Both mux inputs are registers updated only on a fetch, so instr holds
  // its last value between fetches.
  assign instr      = fill_sel_q ? FILL_WORD : ram_rdata;
  assign instrValid = instr_valid_q;
  assign addrErr    = addr_err_q;
  assign loadReady  = load_ready_q;
  assign loadDone   = load_done_q;
  assign progLen    = prog_len_q;
  assign running    = running_q;

endmodule : imem_loader

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Parametrised instruction memory for the image-downsampling processor, generalising the fixed 8-bit/512-byte instruction RAM.
- Adds a run-time program-load port, replacing the file-based init, so a host/UART front end streams the program in before execution.
- Adds a fetch valid handshake, program-length bounds checking and a load/run mode FSM.
- Sits between the loader front end and the control unit's FETCH stage.

Parameters:
DATA_W, 8, instruction word width in bits
ADDR_W, 9, address width; fetch address and write pointer width
DEPTH, 512, number of words; must be <= 2**ADDR_W
FILL_WORD, 0, value returned on an out-of-range fetch (a NOP/HALT opcode)

Ports:
clk  in  1  clock, all state changes on rising edge
rstN  in  1  reset, asynchronous, active-low
loadStart  in  1  begin (or restart) program load
loadValid  in  1  loadData is valid this cycle
loadData  in  DATA_W  program word to store
loadLast  in  1  qualifies the final word of the program (with loadValid)
loadReady  out  1  block accepts load words (high in LOAD only)
loadDone  out  1  one-cycle pulse when load completes
FETCH  in  1  fetch request from control unit
iAddr  in  ADDR_W  fetch address
instr  out  DATA_W  fetched instruction
instrValid  out  1  one-cycle pulse, instr updated this cycle
addrErr  out  1  one-cycle pulse, fetch address >= progLen
progLen  out  ADDR_W+1  number of words loaded by the last completed load
running  out  1  high in RUN state

Behaviour:
- Reset (rstN low, async): state=IDLE; instr=0, instrValid=0, addrErr=0, loadReady=0, loadDone=0, progLen=0, running=0, wrPtr=0. Memory array is not reset.
- State IDLE:
  - loadStart -> LOAD with wrPtr=0.
  - FETCH ignored.
- State LOAD:
  - loadReady=1.
  - On loadValid: mem[wrPtr]<=loadData and wrPtr<=wrPtr+1.
  - If loadLast, or wrPtr==DEPTH-1, with that word: progLen<=wrPtr+1, loadDone=1 next cycle, state -> RUN.
  - Any further words in the same cycle are not possible. Writes past DEPTH-1 never occur.
  - loadStart in LOAD restarts: wrPtr=0, no write that cycle even if loadValid.
  - FETCH ignored.
- State RUN:
  - running=1, loadReady=0.
  - FETCH with iAddr<progLen: next edge instr<=mem[iAddr], instrValid=1. Latency is 1 cycle, back-to-back fetches allowed every cycle.
  - FETCH with iAddr>=progLen: next edge instr<=FILL_WORD, instrValid=1, addrErr=1.
  - loadStart -> LOAD with wrPtr=0. The previous progLen is kept until the new load completes.
- Simultaneous loadStart and FETCH in RUN: loadStart wins; the fetch is dropped (instrValid stays 0).
- Outside a valid fetch, instr holds its last value; instrValid/addrErr/loadDone are single-cycle pulses.
- Reset mid-LOAD: return to IDLE, progLen=0. Partial data stays in the array but is unreachable until a new load completes.
- Zero-length program is impossible: the minimum load is 1 word (loadLast on the first word gives progLen=1).

Decomposition:
- Shared package holds:
  - state encoding (IDLE=2'd0, LOAD=2'd1, RUN=2'd2)
  - default DATA_W/ADDR_W/DEPTH constants
  - NOP/HALT opcode constant used for FILL_WORD
- One sub-module, imem_ram: single-port synchronous RAM (DEPTH x DATA_W), one write port plus a registered read port.
  - Keeps the FSM/bounds logic separate from the storage, which will be inferred as block RAM.

Test Plan:
- Reset then FETCH iAddr=0 in IDLE -> instrValid stays 0, instr=0, running=0.
- loadStart; stream 10 words 0x10..0x19 with loadLast on the 10th -> loadReady=1 during LOAD, loadDone pulses once, progLen=10, running=1.
- After that load, FETCH iAddr=3, then iAddr=9 on consecutive cycles -> instr=0x13 then 0x19, instrValid high for 2 consecutive cycles, addrErr=0.
- FETCH iAddr=10 (FILL_WORD=0) -> instr=0x00, instrValid=1, addrErr=1 for one cycle.
- In RUN, assert loadStart and FETCH iAddr=0 together -> no instrValid; state LOAD; progLen still 10 until the reload of 3 words completes, then progLen=3.
- Load DEPTH words with loadLast never asserted -> auto-completes at word DEPTH-1, progLen=512.
- Separately, pull rstN low after 5 words of a load -> progLen=0, loadReady=0, running=0 immediately (async).
